sepe_dup_scheduler: RTL and testbench
=====================================

# sepe_dup_scheduler

Phase controller for the SQED duplicate-instruction FIFO path. It drives `exe_dup` into the FIFO top, alternating between an ORIG phase, in which original instructions are written, and a DUP phase, in which the queued duplicates are drained. It keeps a running count of pending duplicate entries, weighted by each instruction's duplicate count, so the two phases stay balanced. It also raises `qed_ready` at consistent check points and a sticky `err` on protocol violations.

## Interface
Parameters:
- `CNT_W`, 16, width of the original/duplicate commit counters (wrap modulo 2^CNT_W).
- `PEND_W`, 8, width of the pending-duplicate-entry counter.
- `MAX_PENDING`, 32, pending level that forces a switch to DUP.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: global enable, same signal as the FIFO top's `ena`.
- `sw_req` in 1: free/symbolic request to switch ORIG->DUP.
- `orig_accept` in 1: an original was written this cycle (equals `dup_fifo_wt`).
- `orig_dup_num` in 4: duplicate entries generated by that original, 0..8.
- `dup_accept` in 1: one duplicate entry was read this cycle (equals `dup_fifo_rd`).
- `dup_fifo_almost_full` in 1: duplicate FIFO almost-full flag.
- `exe_dup` out 1: registered phase select; 1 = DUP phase.
- `pending` out PEND_W: duplicate entries written but not yet read.
- `orig_cnt` out CNT_W: originals committed.
- `dup_cnt` out CNT_W: duplicate entries committed.
- `qed_ready` out 1: registered consistency point.
- `err` out 1: sticky protocol-violation flag.

## Operation
- States: IDLE, ORIG, DUP. Encoding is free. `exe_dup` = (state == DUP), taken directly from the state register.
- Next pending: `pend_nx = pending + (orig_accept ? orig_dup_num : 0) - (dup_accept ? 1 : 0)`.
  - Compute at PEND_W+1 bits.
  - Overflow (result > 2^PEND_W-1) or underflow (dup_accept while pending==0) sets `err`. `pending` then holds its old value.
- Counters:
  - `orig_cnt` +1 per `orig_accept`.
  - `dup_cnt` +1 per `dup_accept`.
  - Both wrap; neither is gated by state.
- Transitions are evaluated only when `ena`=1. With `ena`=0 the state holds, but counters still update.
  - IDLE -> ORIG unconditionally.
  - ORIG -> DUP when `pend_nx != 0` and (`sw_req` | `dup_fifo_almost_full` | `pend_nx >= MAX_PENDING`).
  - DUP -> ORIG when `pend_nx == 0`.
  - Otherwise hold.
- `err` set conditions (sticky until `rst`):
  - `orig_accept` while `exe_dup`=1.
  - `dup_accept` while `exe_dup`=0.
  - `orig_accept` & `dup_accept` in the same cycle.
  - `orig_dup_num > 8` with `orig_accept`.
  - Pending overflow or underflow.
- `qed_ready` next = (next state == ORIG) & (`pend_nx` == 0) & (next `orig_cnt` != 0) & ~(next `err`).

## Timing
- Reset, in the cycle after `rst` is sampled high:
  - state = IDLE.
  - `exe_dup`, `pending`, `orig_cnt`, `dup_cnt`, `qed_ready`, `err` = 0.
- A reset mid-DUP discards all pending bookkeeping. The FIFO top resets in the same cycle.
- All outputs are registered, with a 1-cycle latency from accept pulses to counter and pending updates.
- A phase change takes effect on `exe_dup` one cycle after the condition is seen. The FIFO top gates its accepts with `exe_dup` combinationally, so no accept of the wrong kind can occur in the switch cycle.
- First ORIG cycle: the cycle after the first `ena`=1 following reset.
- Simultaneous events:
  - An `orig_accept` in the same cycle as the switch condition is included in `pend_nx` and so counts toward the switch.
  - A final `dup_accept` that brings `pend_nx` to 0 returns the block to ORIG on the next cycle.
- `orig_dup_num`=0 (NOP-like original) adds nothing to `pending`. Such an instruction alone cannot trigger DUP.

## Test plan
- Reset, then `ena`=1:
  - Cycle 1: state IDLE, all outputs 0.
  - Cycle 2: ORIG, with `exe_dup`=0 and `qed_ready`=0.
- Three `orig_accept`s with `orig_dup_num`=2, then `sw_req`:
  - `pending`=6 and `exe_dup`=1 the next cycle.
  - Six `dup_accept`s follow.
  - Then `exe_dup`=0, `pending`=0, `orig_cnt`=3, `dup_cnt`=6, `qed_ready`=1.
- Forced switch: `orig_dup_num`=8 with `sw_req`=0:
  - After 4 accepts, `pending`=32 >= MAX_PENDING.
  - `exe_dup`=1 the next cycle.
- Violations, each after a fresh reset:
  - `dup_accept` in ORIG -> `err`=1 and `pending` unchanged.
  - `orig_accept` & `dup_accept` together -> `err`=1.
  - In both cases `err` stays 1 until `rst`.
- `ena`=0 during DUP with `pending`=2 and no accepts -> state and `exe_dup` hold for 10 cycles. Re-enable with 2 `dup_accept`s -> ORIG.
- `rst` asserted in DUP with `pending`=5 -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/sepe_dup_scheduler.sv
// sepe_dup_scheduler: ORIG/DUP phase controller for the SQED duplicate FIFO.
// Tracks pending duplicate entries (weighted by each original's dup count),
// commit counters, a consistency-point flag and a sticky protocol error.
module sepe_dup_scheduler #(
  parameter int CNT_W       = 16,
  parameter int PEND_W      = 8,
  parameter int MAX_PENDING = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sw_req,
  input  logic              orig_accept,
  input  logic [3:0]        orig_dup_num,
  input  logic              dup_accept,
  input  logic              dup_fifo_almost_full,
  output logic              exe_dup,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  orig_cnt,
  output logic [CNT_W-1:0]  dup_cnt,
  output logic              qed_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ORIG = 2'd1, DUP = 2'd2} state_t;

  state_t             state, state_nx;
  logic [PEND_W:0]    pend_sum;
  logic [PEND_W:0]    pend_add;
  logic [PEND_W:0]    pend_sub;
  logic               pend_udf, pend_ovf, viol;
  logic [PEND_W-1:0]  pend_nx;
  logic [CNT_W-1:0]   orig_cnt_nx, dup_cnt_nx;
  logic               err_nx, qed_nx;

  // Pending bookkeeping one bit wider so overflow is visible; on over/underflow
  // the stored value is kept and only err records the event.
  always_comb begin
    pend_add = orig_accept ? (PEND_W+1)'(orig_dup_num) : '0;
    pend_sub = dup_accept  ? (PEND_W+1)'(1) : '0;
    pend_sum = {1'b0, pending} + pend_add - pend_sub;
    pend_udf = dup_accept & (pending == '0);
    pend_ovf = pend_sum[PEND_W] & ~pend_udf;
    pend_nx  = (pend_udf | pend_ovf) ? pending : pend_sum[PEND_W-1:0];
  end

  // Protocol checks and free-running commit counters (not gated by phase or ena).
  always_comb begin
    viol = (orig_accept & exe_dup)
         | (dup_accept & ~exe_dup)
         | (orig_accept & dup_accept)
         | (orig_accept & (orig_dup_num > 4'd8))
         | pend_udf | pend_ovf;
    err_nx      = err | viol;
    orig_cnt_nx = orig_cnt + CNT_W'(orig_accept);
    dup_cnt_nx  = dup_cnt  + CNT_W'(dup_accept);
  end

  // State register plus all registered datapath outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
      qed_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pend_nx;
      orig_cnt  <= orig_cnt_nx;
      dup_cnt   <= dup_cnt_nx;
      qed_ready <= qed_nx;
      err       <= err_nx;
    end
  end

  // Next-state: phases only move while ena is high; an accept in the same
  // cycle already counts through pend_nx.
  always_comb begin
    state_nx = state;
    if (ena) begin
      case (state)
        IDLE: state_nx = ORIG;
        ORIG: if ((pend_nx != '0) &&
                  (sw_req || dup_fifo_almost_full ||
                   (32'(pend_nx) >= 32'(MAX_PENDING))))
                state_nx = DUP;
        DUP:  if (pend_nx == '0) state_nx = ORIG;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs: phase select straight from the state register, and the next
  // consistency point (balanced, something committed, no error).
  always_comb begin
    exe_dup = (state == DUP);
    qed_nx  = (state_nx == ORIG) & (pend_nx == '0) & (orig_cnt_nx != '0) & ~err_nx;
  end

endmodule

// File: tb/tb_sepe_dup_scheduler.sv
// Bench for sepe_dup_scheduler: each scenario builds a stimulus plan with
// expected outputs; expected values go to a scoreboard queue as the stimulus
// is driven and are popped and compared one cycle later.
module tb_sepe_dup_scheduler;
  localparam int CNT_W  = 16;
  localparam int PEND_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, ena, sw_req, orig_accept, dup_accept, dup_fifo_almost_full;
  logic [3:0]        orig_dup_num;
  logic              exe_dup, qed_ready, err;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  orig_cnt, dup_cnt;

  sepe_dup_scheduler #(.CNT_W(CNT_W), .PEND_W(PEND_W), .MAX_PENDING(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sw_req(sw_req),
    .orig_accept(orig_accept), .orig_dup_num(orig_dup_num),
    .dup_accept(dup_accept), .dup_fifo_almost_full(dup_fifo_almost_full),
    .exe_dup(exe_dup), .pending(pending), .orig_cnt(orig_cnt), .dup_cnt(dup_cnt),
    .qed_ready(qed_ready), .err(err)
  );

  typedef struct packed {
    logic r, e, s, oa; logic [3:0] n; logic da, af;
  } stim_t;
  typedef struct packed {
    logic exe; logic [7:0] pend; logic [15:0] oc, dc; logic qr, er;
  } obs_t;
  typedef struct packed { stim_t s; obs_t o; } step_t;

  step_t plan_q[$];
  obs_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Append one cycle of stimulus and the outputs expected after its clock edge.
  task automatic add(input logic r, e, s, oa, input logic [3:0] n, input logic da, af,
                     input logic exe, input logic [7:0] pend, input logic [15:0] oc, dc,
                     input logic qr, er);
    step_t t;
    t.s.r = r; t.s.e = e; t.s.s = s; t.s.oa = oa; t.s.n = n; t.s.da = da; t.s.af = af;
    t.o.exe = exe; t.o.pend = pend; t.o.oc = oc; t.o.dc = dc; t.o.qr = qr; t.o.er = er;
    plan_q.push_back(t);
  endtask

  // Reset cycle (IDLE, all zero) followed by the first enabled cycle (ORIG).
  task automatic add_reset();
    add(1,1,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,0,0,0);
  endtask

  // Drive one planned cycle and record its expectation in the scoreboard.
  task automatic drive_step(input step_t t);
    rst = t.s.r; ena = t.s.e; sw_req = t.s.s; orig_accept = t.s.oa;
    orig_dup_num = t.s.n; dup_accept = t.s.da; dup_fifo_almost_full = t.s.af;
    exp_q.push_back(t.o);
    @(posedge clk); #1;
  endtask

  function automatic obs_t observe();
    obs_t g;
    g.exe = exe_dup; g.pend = pending; g.oc = orig_cnt; g.dc = dup_cnt;
    g.qr = qed_ready; g.er = err;
    return g;
  endfunction

  task automatic test_reset();
    step_t t; obs_t g, w; int i;
    add_reset();
    add(0,1,0,0,0,0,0, 0,0,0,0,0,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL reset step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  task automatic test_basic();
    step_t t; obs_t g, w; int i;
    add_reset();
    for (int k = 1; k <= 3; k++) add(0,1,0,1,2,0,0, 0,8'(2*k),16'(k),0,0,0);
    add(0,1,1,0,0,0,0, 1,6,3,0,0,0);
    for (int k = 1; k <= 5; k++) add(0,1,0,0,0,1,0, 1,8'(6-k),3,16'(k),0,0);
    add(0,1,0,0,0,1,0, 0,0,3,6,1,0);
    add(0,1,0,0,0,0,0, 0,0,3,6,1,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL basic step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  // Continues from test_basic: accept and switch request in the same cycle,
  // then a single drain straight back to ORIG.
  task automatic test_back_to_back();
    step_t t; obs_t g, w; int i;
    add(0,1,1,1,1,0,0, 1,1,4,6,0,0);
    add(0,1,0,0,0,1,0, 0,0,4,7,1,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  task automatic test_forced();
    step_t t; obs_t g, w; int i;
    add_reset();
    for (int k = 1; k <= 3; k++) add(0,1,0,1,8,0,0, 0,8'(8*k),16'(k),0,0,0);
    add(0,1,0,1,7,0,0, 0,31,4,0,0,0);
    add(0,1,0,1,1,0,0, 1,32,5,0,0,0);
    add_reset();
    for (int k = 1; k <= 3; k++) add(0,1,0,1,8,0,0, 0,8'(8*k),16'(k),0,0,0);
    add(0,1,0,1,8,0,0, 1,32,4,0,0,0);
    add_reset();
    add(0,1,1,1,0,0,0, 0,0,1,0,1,0);
    add(0,1,0,1,1,0,1, 1,1,2,0,0,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL forced step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  task automatic test_violations();
    step_t t; obs_t g, w; int i;
    add_reset();
    add(0,1,0,0,0,1,0, 0,0,0,1,0,1);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0,0,0, 0,0,0,1,0,1);
    add_reset();
    add(0,1,0,1,1,1,0, 0,0,1,1,0,1);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0,0,0, 0,0,1,1,0,1);
    add(1,1,0,0,0,0,0, 0,0,0,0,0,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL violations step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  task automatic test_ena_hold();
    step_t t; obs_t g, w; int i;
    add_reset();
    add(0,1,0,1,2,0,0, 0,2,1,0,0,0);
    add(0,1,1,0,0,0,0, 1,2,1,0,0,0);
    for (int k = 0; k < 10; k++) add(0,0,0,0,0,0,0, 1,2,1,0,0,0);
    add(0,1,0,0,0,1,0, 1,1,1,1,0,0);
    add(0,1,0,0,0,1,0, 0,0,1,2,1,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL ena_hold step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  task automatic test_rst_in_dup();
    step_t t; obs_t g, w; int i;
    add_reset();
    add(0,1,0,1,5,0,0, 0,5,1,0,0,0);
    add(0,1,1,0,0,0,0, 1,5,1,0,0,0);
    add(1,1,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,0,0,0);
    i = 0;
    while (plan_q.size() > 0) begin
      t = plan_q.pop_front(); drive_step(t);
      g = observe(); w = exp_q.pop_front(); n_vec++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL rst_in_dup step %0d: got %h want %h", i, g, w);
      end
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sw_req = 1'b0; orig_accept = 1'b0;
    orig_dup_num = 4'd0; dup_accept = 1'b0; dup_fifo_almost_full = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_forced();
    test_violations();
    test_ena_hold();
    test_rst_in_dup();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
